// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Message-locked round-robin arbiter that shares one UART transmitter between
// N_REQ byte-stream requesters. Once a requester wins, it owns the transmitter
// until the transmitter accepts a byte flagged last, so messages never interleave.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to build the idle-stall counter
// that force-releases a lock after TIMEOUT clocks with no byte offered.
module uart_tx_arbiter #(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] TIMEOUT = 16'hFFFF,
    localparam int         IDW     = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic [IDW-1:0]     grant_id,
    output logic               busy,
    output logic               timeout
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] last_ptr_q;

    // Round-robin scan results.
    logic           rr_found;
    logic [IDW-1:0] rr_idx;
    logic [IDW-1:0] rr_cand;

    // Signals of the current grant holder.
    logic           sel_valid;
    logic           sel_last;
    logic [7:0]     sel_data;

    // Pass-through enable: the lock is dropped in the very cycle reset is seen,
    // so no byte slips through while the state register is being cleared.
    logic           pass_en;
    logic           hs;
    logic           stall_hit;

    // Scan requests starting one past the previous message owner, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned; otherwise a latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_cand = IDW'((int'(last_ptr_q) + k) % N_REQ);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Select the grant holder's valid/last/data lanes.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign pass_en  = (state_q == S_LOCKED) && !rst;
    assign tx_valid = pass_en && sel_valid;
    assign tx_data  = pass_en ? sel_data : 8'h00;
    assign hs       = tx_valid && tx_ready;

    // Route the transmitter's ready back to the grant holder only.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pass_en && (grant_q == IDW'(i))) begin
                req_ready[i] = tx_ready;
            end
        end
    end

    // Arbitration FSM: grant in IDLE, release on an accepted last byte (or a stall timeout).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_ptr_q <= IDW'(N_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rr_found) begin
                        grant_q <= rr_idx;
                        state_q <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (hs && sel_last) begin
                        state_q    <= S_IDLE;
                        last_ptr_q <= grant_q;
                    end else if (stall_hit) begin
                        state_q    <= S_IDLE;
                        last_ptr_q <= grant_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt_q;
    logic        timeout_q;

    // Reaching TIMEOUT means this cycle is the TIMEOUT-th consecutive cycle without a byte.
    assign stall_hit = (state_q == S_LOCKED) && !sel_valid && (stall_cnt_q == (TIMEOUT - 16'd1));

    // Count locked cycles with no byte offered; backpressure from tx_ready is not a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= stall_hit;
            if ((state_q == S_IDLE) || hs) begin
                stall_cnt_q <= '0;
            end else if (!sel_valid) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign stall_hit          = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    assign grant_id = grant_q;
    assign busy     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a message-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             timeout;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(16'd8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester byte plans: {last, data}.
    logic [8:0] plan    [N][$];
    logic [8:0] live    [N][$];
    logic [8:0] model_q [N][$];

    logic [7:0] obs_data[$];
    int         obs_src[$];
    int         obs_cyc[$];
    logic [7:0] exp_data[$];
    int         exp_src[$];

    int first_ready[N];
    int ready_bad;
    int stall_bad;
    int stall_cycles;
    int stall_src;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) plan[i].delete();
    endtask

    // Reference model: whole messages granted round-robin among requesters with
    // messages left, starting after requester N-1.
    function automatic void build_expected();
        int         ptr;
        int         src;
        bit         found;
        logic [8:0] ent;
        exp_data.delete();
        exp_src.delete();
        for (int i = 0; i < N; i++) model_q[i] = plan[i];
        ptr   = N - 1;
        src   = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && model_q[(ptr + k) % N].size() > 0) begin
                    found = 1'b1;
                    src   = (ptr + k) % N;
                end
            end
            if (found) begin
                do begin
                    ent = model_q[src].pop_front();
                    exp_data.push_back(ent[7:0]);
                    exp_src.push_back(src);
                end while (!ent[8] && model_q[src].size() > 0);
                ptr = src;
            end
        end
    endfunction

    // Requester/transmitter driver. mode 0: tx_ready always 1; 1: random;
    // 2: tx_ready low for cycles 2..101. Requesters hold valid while they have
    // bytes, except random gaps (0..gap_max) inside their own message.
    task automatic run_traffic(input int mode, input int gap_max, input int max_cycles);
        int         cyc;
        int         gap [N];
        bit         done;
        logic [8:0] ent;
        for (int i = 0; i < N; i++) begin
            live[i]        = plan[i];
            gap[i]         = 0;
            first_ready[i] = -1;
        end
        obs_data.delete();
        obs_src.delete();
        obs_cyc.delete();
        ready_bad    = 0;
        stall_bad    = 0;
        stall_cycles = 0;
        cyc          = 0;
        done         = 1'b1;
        for (int i = 0; i < N; i++) if (live[i].size() > 0) done = 1'b0;
        while (!done) begin
            for (int i = 0; i < N; i++) begin
                if (live[i].size() > 0 && gap[i] == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = live[i][0][7:0];
                    req_last[i]        = live[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i]        = 1'($urandom);
                end
            end
            case (mode)
                1:       tx_ready = ($urandom_range(0, 3) != 0);
                2:       tx_ready = !(cyc >= 2 && cyc <= 101);
                default: tx_ready = 1'b1;
            endcase
            @(negedge clk);
            if ($countones(req_ready) > 1) ready_bad++;
            if (!busy && (tx_valid || tx_data != 8'h00 || req_ready != '0)) ready_bad++;
            if (!tx_ready && req_ready != '0) ready_bad++;
            if (timeout !== 1'b0) ready_bad++;
            if (mode == 2 && !tx_ready) begin
                stall_cycles++;
                if (!tx_valid || req_ready != '0 || live[stall_src].size() == 0)
                    stall_bad++;
                else if (tx_data !== live[stall_src][0][7:0])
                    stall_bad++;
            end
            if (tx_valid && tx_ready) begin
                obs_data.push_back(tx_data);
                obs_src.push_back(int'(grant_id));
                obs_cyc.push_back(cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && first_ready[i] < 0) first_ready[i] = cyc;
                if (req_ready[i] && req_valid[i] && live[i].size() > 0) begin
                    ent    = live[i].pop_front();
                    gap[i] = ent[8] ? 0 : $urandom_range(0, gap_max);
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
            end
            done = 1'b1;
            for (int i = 0; i < N; i++) if (live[i].size() > 0) done = 1'b0;
            cyc++;
            if (!done && cyc >= max_cycles) begin
                n_checks++;
                n_fail++;
                $display("FAIL traffic_budget: %0d cycles without draining all requesters", cyc);
                done = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        tx_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = 32'($urandom);
        req_last  = '1;
        tx_ready  = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_priority();
        do_reset();
        clear_plan();
        plan[1].push_back({1'b1, 8'hA1});
        plan[3].push_back({1'b1, 8'hA3});
        run_traffic(0, 0, 50);
        n_checks++; if (obs_data.size() != 2) begin n_fail++; $display("FAIL prio_count: got %0d want 2", obs_data.size()); end
        else begin
            n_checks++; if (obs_data[0] !== 8'hA1 || obs_src[0] != 1) begin n_fail++; $display("FAIL prio_first: got %h/%0d want a1/1", obs_data[0], obs_src[0]); end
            n_checks++; if (obs_data[1] !== 8'hA3 || obs_src[1] != 3) begin n_fail++; $display("FAIL prio_second: got %h/%0d want a3/3", obs_data[1], obs_src[1]); end
            n_checks++; if (obs_cyc[0] != 1) begin n_fail++; $display("FAIL prio_latency: got cycle %0d want 1", obs_cyc[0]); end
            n_checks++; if (obs_cyc[1] != 3) begin n_fail++; $display("FAIL prio_dead_cycle: got cycle %0d want 3", obs_cyc[1]); end
        end
        n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL prio_protocol: got %0d violations want 0", ready_bad); end
    endtask

    task automatic test_message_lock();
        logic [7:0] want_d [4];
        int         want_c [4];
        want_d = '{8'h10, 8'h11, 8'h12, 8'h20};
        want_c = '{1, 2, 3, 5};
        do_reset();
        clear_plan();
        plan[0].push_back({1'b0, 8'h10});
        plan[0].push_back({1'b0, 8'h11});
        plan[0].push_back({1'b1, 8'h12});
        plan[2].push_back({1'b1, 8'h20});
        run_traffic(0, 0, 50);
        n_checks++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL lock_count: got %0d want 4", obs_data.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (obs_data[k] !== want_d[k] || obs_cyc[k] != want_c[k]) begin
                    n_fail++;
                    $display("FAIL lock_byte%0d: got %h@%0d want %h@%0d", k, obs_data[k], obs_cyc[k], want_d[k], want_c[k]);
                end
            end
        end
        n_checks++; if (first_ready[2] != 5) begin n_fail++; $display("FAIL lock_ready2: first req_ready[2] at %0d want 5", first_ready[2]); end
    endtask

    task automatic test_fairness();
        do_reset();
        clear_plan();
        for (int i = 0; i < N; i++)
            for (int m = 0; m < 3; m++)
                plan[i].push_back({1'b1, 4'(i), 4'(m)});
        run_traffic(0, 0, 100);
        n_checks++; if (obs_data.size() != 12) begin n_fail++; $display("FAIL fair_count: got %0d want 12", obs_data.size()); end
        else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++;
                if (obs_src[k] != k % N || obs_data[k] !== {4'(k % N), 4'(k / N)} || obs_cyc[k] != 1 + 2 * k) begin
                    n_fail++;
                    $display("FAIL fair_grant%0d: got src %0d data %h cyc %0d want src %0d data %h cyc %0d",
                             k, obs_src[k], obs_data[k], obs_cyc[k], k % N, {4'(k % N), 4'(k / N)}, 1 + 2 * k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_plan();
        plan[1].push_back({1'b0, 8'hB0});
        plan[1].push_back({1'b0, 8'hB1});
        plan[1].push_back({1'b1, 8'hB2});
        stall_src = 1;
        run_traffic(2, 0, 300);
        n_checks++; if (stall_cycles != 100) begin n_fail++; $display("FAIL bp_stall_len: got %0d want 100", stall_cycles); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad stall cycles want 0", stall_bad); end
        n_checks++; if (obs_data.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", obs_data.size()); end
        else begin
            n_checks++; if (obs_data[0] !== 8'hB0 || obs_data[1] !== 8'hB1 || obs_data[2] !== 8'hB2) begin
                n_fail++; $display("FAIL bp_bytes: got %h %h %h want b0 b1 b2", obs_data[0], obs_data[1], obs_data[2]); end
            n_checks++; if (obs_cyc[1] != 102 || obs_cyc[2] != 103) begin
                n_fail++; $display("FAIL bp_resume: got %0d %0d want 102 103", obs_cyc[1], obs_cyc[2]); end
        end
        n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL bp_protocol: got %0d violations want 0", ready_bad); end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        // Requester 2 completes a message first so the priority pointer moves.
        req_valid = 4'b0100; req_data[23:16] = 8'h2F; req_last = 4'b0100; tx_ready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2F) begin n_fail++; $display("FAIL rmm_pre: got %b/%h want 1/2f", tx_valid, tx_data); end
        tick();
        req_valid = 4'b0001; req_data[7:0] = 8'h40; req_last = 4'b0000;
        tick();
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h40) begin n_fail++; $display("FAIL rmm_byte1: got %b/%h want 1/40", tx_valid, tx_data); end
        tick();
        req_data[7:0] = 8'h41;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL rmm_byte2: got %b/%h want 1/41", tx_valid, tx_data); end
        tick();
        rst = 1'b1; req_data[7:0] = 8'h42;
        tick();
        rst = 1'b0; req_valid = 4'b1001; req_data[31:24] = 8'h3C; req_last = 4'b1000;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmm_busy: got %b want 0", busy); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmm_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rmm_grant_id: got %0d want 0", grant_id); end
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h42) begin
            n_fail++; $display("FAIL rmm_priority: got busy %b grant %0d data %h want 1/0/42", busy, grant_id, tx_data); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req_valid = 4'b0100; req_data[23:16] = 8'h50; req_last = 4'b0000; tx_ready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h50) begin n_fail++; $display("FAIL to_first: got %b/%h want 1/50", tx_valid, tx_data); end
        tick();
        // Requester 2 stalls; requesters 0 and 3 wait with one-byte messages.
        req_valid = 4'b1001; req_data[7:0] = 8'h0A; req_data[31:24] = 8'h3A; req_last = 4'b1001;
        bad = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (busy !== 1'b1 || timeout !== 1'b0 || tx_valid !== 1'b0 || grant_id !== 2'd2) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL to_stall: got %0d bad stall cycles want 0", bad); end
        @(negedge clk);
`ifdef UART_TX_ARB_TIMEOUT_EN
        n_checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL to_release: got timeout %b busy %b want 1/0", timeout, busy); end
        tick();
        @(negedge clk);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'h3A) begin
            n_fail++; $display("FAIL to_next_grant: got busy %b grant %0d data %h want 1/3/3a", busy, grant_id, tx_data); end
`else
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_hold: got timeout %b busy %b want 0/1", timeout, busy); end
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || grant_id !== 2'd2 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_still_locked: got busy %b grant %0d valid %b want 1/2/0", busy, grant_id, tx_valid); end
`endif
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        int nmsg;
        int len;
        for (int round = 0; round < 6; round++) begin
            do_reset();
            clear_plan();
            for (int i = 0; i < N; i++) begin
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        plan[i].push_back({(b == len - 1), 8'($urandom)});
                end
            end
            build_expected();
            run_traffic(1, 3, 3000);
            n_checks++;
            if (obs_data.size() != exp_data.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d want %0d", round, obs_data.size(), exp_data.size());
            end else begin
                for (int k = 0; k < exp_data.size(); k++) begin
                    n_checks++;
                    if (obs_data[k] !== exp_data[k] || obs_src[k] != exp_src[k]) begin
                        n_fail++;
                        $display("FAIL rand%0d_byte%0d: got %h from %0d want %h from %0d",
                                 round, k, obs_data[k], obs_src[k], exp_data[k], exp_src[k]);
                    end
                end
            end
            n_checks++; if (ready_bad != 0) begin n_fail++; $display("FAIL rand%0d_protocol: got %0d violations want 0", round, ready_bad); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        stall_src = 1;
        test_reset();
        test_priority();
        test_message_lock();
        test_fairness();
        test_backpressure();
        test_reset_mid_message();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` between `N_REQ` byte-stream requesters. Grants are message-locked: once a requester wins, it keeps the transmitter until it hands over a byte flagged `last`, so messages from different sources are never interleaved on the serial line. The block sits directly upstream of the transmitter's `valid`/`data`/`ready` port.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `TIMEOUT`, default 16'hFFFF: idle-stall limit in clocks. Used only when `UART_TX_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: single clock.
- `rst` in 1: reset. Synchronous, active-high.
- `req_valid` in N_REQ: per-requester byte valid.
- `req_data` in 8*N_REQ: requester i's byte is on bits [8i+7:8i].
- `req_last` in N_REQ: the byte is the final byte of its message.
- `req_ready` out N_REQ: the byte is accepted this cycle.
- `tx_valid` out 1: to the transmitter's `valid` input.
- `tx_data` out 8: to the transmitter's `data` input.
- `tx_ready` in 1: from the transmitter's `ready` output.
- `grant_id` out $clog2(N_REQ): current or most recent grant holder.
- `busy` out 1: high while a grant is locked.
- `timeout` out 1: one-cycle pulse when a lock is force-released.

## Operation
- FSM has two states, IDLE and LOCKED.
- **IDLE:**
  - Scan `req_valid` in round-robin order, starting at `last_ptr+1` and wrapping modulo N_REQ.
  - The first set bit wins: register `grant_id` and move to LOCKED.
  - With no requests, stay in IDLE.
  - No byte is passed in IDLE.
- **LOCKED, pass-through (combinational):**
  - `tx_valid = req_valid[grant_id]`.
  - `tx_data = req_data[grant_id]`.
  - `req_ready[grant_id] = tx_ready`.
  - All other `req_ready` bits are 0.
- **Byte handshake:** occurs when `req_valid[g] & tx_ready`.
  - If `req_last[g]` is set, go to IDLE and set `last_ptr <= g`.
  - Otherwise stay LOCKED.
- `busy` = (state == LOCKED).
- Outside LOCKED, `tx_valid` = 0 and `tx_data` = 8'h00.
- Requests that arrive while LOCKED wait. A requester that deasserts `req_valid` while not granted loses nothing.
- **Reset values:**
  - State IDLE; `last_ptr` = N_REQ-1, so requester 0 has first priority.
  - `grant_id` = 0.
  - `busy`, `tx_valid`, `timeout` = 0; `req_ready` = 0.
- **Reset mid-message:** the lock drops immediately and no further byte is passed. A byte already accepted by the transmitter completes on the line; the arbiter does not track it.
- **Simultaneous events:**
  - A last-byte handshake and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle, using the updated `last_ptr`.
  - A single-byte message (`last` on its first byte) is legal.

## Timing
- Arbitration to first byte: a request seen in IDLE at cycle t gives `tx_valid` at t+1 (one-cycle grant latency).
- Between messages there is at least one dead cycle, the IDLE arbitration cycle.
- Back-to-back bytes within a message are limited only by `tx_ready`. The transmitter asserts `ready` in the cycle its stop bit ends, so in-message bytes stream with no gap.
- Outputs are combinational from registered state plus `req_*` and `tx_ready`. No combinational path exists from `tx_ready` to `tx_valid`.

## Configuration
- **`UART_TX_ARB_TIMEOUT_EN` defined:**
  - A 16-bit stall counter clears on every handshake and on entry to LOCKED.
  - It increments each LOCKED cycle in which `req_valid[grant_id]` = 0.
  - When it reaches `TIMEOUT`, go to IDLE, set `last_ptr <= grant_id`, and pulse `timeout` for one cycle.
  - Stalls caused only by `tx_ready` = 0 are not counted.
- **Not defined:** no counter is built, `timeout` is tied to 0, and a lock persists until `last` is accepted.

## Test plan
- **Priority after reset:** after `rst`, raise `req_valid` = 4'b1010 at the same cycle, each requester sending 1-byte messages (0xA1 from requester 1, 0xA3 from requester 3). Required: `grant_id` 1 then 3; `tx_data` sequence 0xA1, 0xA3; one IDLE cycle between them.
- **Message lock:** requester 0 sends 3 bytes 0x10, 0x11, 0x12 with `last` on 0x12; requester 2 requests from the first cycle. Required: the transmitter sees 0x10, 0x11, 0x12 before requester 2's byte; `req_ready[2]` stays 0 throughout.
- **Fairness:** all 4 requesters continuously send 1-byte messages. Required: grant order 0, 1, 2, 3, 0, 1 and so on; no requester is skipped.
- **Backpressure:** hold `tx_ready` = 0 for 100 cycles during requester 1's message. Required: `tx_valid` = 1 and `req_ready` = 0 for the whole stall; byte values are preserved; with the macro defined, `timeout` stays 0.
- **Reset mid-message:** assert `rst` for 1 cycle after the 2nd of 4 bytes. Required: next cycle `busy` = 0, `tx_valid` = 0 and `grant_id` = 0; requester 0 then has first priority.
- **Timeout:** with the macro defined and `TIMEOUT` = 8, requester 2 deasserts `req_valid` mid-message. Required: after exactly 8 stall cycles, a `timeout` pulse, `busy` = 0, and requester 3 is next to be granted if it is pending. Without the macro, `busy` stays 1.
